// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that drains the read port of a FIFO.
// One word is popped per frame; frames can run back-to-back with no idle gap.
//
// Handshake with the FIFO: rempty=0 means rdata is a valid head word. rinc is
// the accept strobe. A word transfers on every rising edge where rinc=1. rinc
// is only raised when the word is valid, the block is enabled, and the line is
// free: the block is idle, or it is in the last cycle of the final stop bit.
module fifo_uart_tx #(
  parameter int DATASIZE     = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                en,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                rempty,
  output logic                rinc,
  output logic                tx,
  output logic                busy,
  output logic [2:0]          state_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATASIZE > 1) ? $clog2(DATASIZE) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATASIZE - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic PAR_EN    = (PARITY != 0);
  localparam logic PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t              state_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [IDX_W-1:0]    bit_idx_q;
  logic                stop_idx_q;
  logic [DATASIZE-1:0] shreg_q;
  logic                par_q;
  logic                tx_q;
  logic                busy_q;

  logic                baud_last;
  logic                frame_end;
  logic                rdata_par;
  logic [DATASIZE-1:0] shreg_d;

  assign baud_last = (baud_q == BAUD_LAST);
  // Last cycle of the final stop bit: the back-to-back pop decision point.
  assign frame_end = (state_q == S_STOP) && baud_last && (stop_idx_q == STOP_LAST);
  // Pop is gated by reset so nothing leaves the FIFO while the block is held.
  assign rinc      = rrst_n & en & ~rempty & ((state_q == S_IDLE) | frame_end);
  assign rdata_par = (^rdata) ^ PAR_ODD;
  assign shreg_d   = shreg_q >> 1;

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign state_o = state_q;

  // Frame sequencer: state, counters, shift register and registered tx/busy.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else if (rinc) begin
      // Word accepted: latch it with its parity and drive the start bit next cycle.
      state_q    <= S_START;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= rdata;
      par_q      <= rdata_par;
      tx_q       <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        S_START: begin
          if (baud_last) begin
            state_q <= S_DATA;
            baud_q  <= '0;
            tx_q    <= shreg_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == IDX_LAST) begin
              bit_idx_q <= '0;
              if (PAR_EN) begin
                state_q <= S_PAR;
                tx_q    <= par_q;
              end else begin
                state_q    <= S_STOP;
                stop_idx_q <= 1'b0;
                tx_q       <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shreg_q   <= shreg_d;
              tx_q      <= shreg_d[0];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_PAR: begin
          if (baud_last) begin
            state_q    <= S_STOP;
            baud_q     <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (stop_idx_q == STOP_LAST) begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: four transmitter instances with different framing options,
// each fed by a small FIFO model; frames are checked cycle by cycle and by a
// UART receiver model against an expected-word queue.
module tb_fifo_uart_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n    [4];
  logic       en_w     [4];
  logic       rempty_w [4];
  logic       rinc_w   [4];
  logic       tx_w     [4];
  logic       busy_w   [4];
  logic [7:0] rdata_w  [4];
  logic [2:0] state_w  [4];

  // FIFO models: head advances on the edge where rinc is high.
  logic [7:0] fmem  [4][512];
  logic [8:0] fhead [4] = '{default: 9'd0};
  logic [8:0] ftail [4];

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      rempty_w[g] = (fhead[g] == ftail[g]);
      rdata_w[g]  = fmem[g][fhead[g]];
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 4; g++)
      if (rinc_w[g] === 1'b1) fhead[g] <= fhead[g] + 9'd1;
  end

  // ---------------- DUTs ----------------
  // 0: 8N1 div 4   1: 8E1 div 4   2: 8O2 div 4   3: 8N1 div 2
  fifo_uart_tx #(.DATASIZE(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .rclk(clk), .rrst_n(rst_n[0]), .en(en_w[0]), .rdata(rdata_w[0]), .rempty(rempty_w[0]),
    .rinc(rinc_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .state_o(state_w[0]));
  fifo_uart_tx #(.DATASIZE(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .rclk(clk), .rrst_n(rst_n[1]), .en(en_w[1]), .rdata(rdata_w[1]), .rempty(rempty_w[1]),
    .rinc(rinc_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .state_o(state_w[1]));
  fifo_uart_tx #(.DATASIZE(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u_dut2 (
    .rclk(clk), .rrst_n(rst_n[2]), .en(en_w[2]), .rdata(rdata_w[2]), .rempty(rempty_w[2]),
    .rinc(rinc_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .state_o(state_w[2]));
  fifo_uart_tx #(.DATASIZE(8), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1)) u_dut3 (
    .rclk(clk), .rrst_n(rst_n[3]), .en(en_w[3]), .rdata(rdata_w[3]), .rempty(rempty_w[3]),
    .rinc(rinc_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .state_o(state_w[3]));

  // ---------------- pop protocol monitor ----------------
  int   viol = 0;
  logic rinc_prev [4] = '{default: 1'b0};

  always begin
    @(negedge clk);
    #2;
    for (int g = 0; g < 4; g++) begin
      if (rinc_w[g] === 1'b1 && rempty_w[g] !== 1'b0) begin
        viol++;
        $display("FAIL rinc_while_empty dut%0d: rinc=1 rempty=%b, required rinc=0", g, rempty_w[g]);
      end
      if (rinc_w[g] === 1'b1 && rinc_prev[g] === 1'b1) begin
        viol++;
        $display("FAIL rinc_consecutive dut%0d: rinc high two cycles in a row, required one-cycle pulse", g);
      end
      rinc_prev[g] = rinc_w[g];
    end
  end

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_word(input int g, input logic [7:0] d);
    fmem[g][ftail[g]] = d;
    ftail[g] = ftail[g] + 9'd1;
  endtask

  // Receiver model: called at negedge+1; finds a start bit within budget
  // cycles, samples mid-bit, checks start/parity/stop, returns the word.
  task automatic uart_rx(input int g, input int cpb, input int par, input int stops,
                         input int budget, output logic [7:0] w, output logic ok);
    int n;
    ok = 1'b1;
    w  = 8'h00;
    n  = 0;
    while (tx_w[g] !== 1'b0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      ok = 1'b0;
      return;
    end
    repeat (cpb / 2) begin @(negedge clk); #1; end
    if (tx_w[g] !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) begin @(negedge clk); #1; end
      w[i] = tx_w[g];
    end
    if (par != 0) begin
      repeat (cpb) begin @(negedge clk); #1; end
      if (tx_w[g] !== ((^w) ^ (par == 2))) ok = 1'b0;
    end
    for (int s = 0; s < stops; s++) begin
      repeat (cpb) begin @(negedge clk); #1; end
      if (tx_w[g] !== 1'b1) ok = 1'b0;
    end
  endtask

  // Single-frame vector record: input at cycle k and expected outputs.
  typedef struct {
    int         k;
    logic       push;
    logic [7:0] din;
    logic       exp_tx;
    logic       exp_busy;
    logic       exp_rinc;
  } vec_t;

  vec_t       vt[$];
  logic       seq_a5 [10];
  logic [7:0] bb     [3];

  initial begin
    vec_t       v;
    logic [7:0] w, wv;
    logic       ok, ex;
    int         pops, f, r, b, fl;

    // stimulus table: 0xA5, 8N1, 4 clocks/bit, pushed at cycle 0
    seq_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k <= 41; k++) begin
      v.k        = k;
      v.push     = (k == 0);
      v.din      = 8'hA5;
      v.exp_rinc = (k == 0);
      v.exp_busy = (k >= 1 && k <= 40);
      v.exp_tx   = (k >= 1 && k <= 40) ? seq_a5[(k - 1) / 4] : 1'b1;
      vt.push_back(v);
    end
    bb = '{8'h00, 8'hFF, 8'h3C};

    for (int g = 0; g < 4; g++) begin
      rst_n[g] = 1'b0;
      en_w[g]  = 1'b0;
      ftail[g] = 9'd0;
    end

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_tx", 32'(tx_w[0]), 32'd1);
    chk("reset_busy", 32'(busy_w[0]), 32'd0);
    chk("reset_rinc", 32'(rinc_w[0]), 32'd0);
    chk("reset_state", 32'(state_w[0]), 32'd0);
    chk("reset_tx_dut3", 32'(tx_w[3]), 32'd1);
    @(negedge clk);
    for (int g = 0; g < 4; g++) rst_n[g] = 1'b1;
    en_w[0] = 1'b1;
    #1;
    chk("idle_empty_rinc", 32'(rinc_w[0]), 32'd0);

    // single 0xA5 frame, table-driven
    foreach (vt[i]) begin
      @(negedge clk);
      if (vt[i].push) push_word(0, vt[i].din);
      #1;
      chk($sformatf("a5_tx k=%0d", vt[i].k), 32'(tx_w[0]), 32'(vt[i].exp_tx));
      chk($sformatf("a5_busy k=%0d", vt[i].k), 32'(busy_w[0]), 32'(vt[i].exp_busy));
      chk($sformatf("a5_rinc k=%0d", vt[i].k), 32'(rinc_w[0]), 32'(vt[i].exp_rinc));
    end

    // en=0 with data present, then back-to-back 0x00, 0xFF, 0x3C
    @(negedge clk);
    en_w[0] = 1'b0;
    for (int i = 0; i < 3; i++) push_word(0, bb[i]);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("en_low_rinc i=%0d", i), 32'(rinc_w[0]), 32'd0);
      chk($sformatf("en_low_tx i=%0d", i), 32'(tx_w[0]), 32'd1);
      @(negedge clk);
    end
    en_w[0] = 1'b1;
    #1;
    chk("en_raise_pop", 32'(rinc_w[0]), 32'd1);
    pops = 1;
    for (int k = 1; k <= 121; k++) begin
      @(negedge clk); #1;
      if (k <= 120) begin
        f  = (k - 1) / 40;
        r  = (k - 1) % 40;
        b  = r / 4;
        wv = bb[f];
        ex = (b == 0) ? 1'b0 : (b <= 8) ? wv[b - 1] : 1'b1;
      end else begin
        ex = 1'b1;
      end
      chk($sformatf("b2b_tx k=%0d", k), 32'(tx_w[0]), 32'(ex));
      chk($sformatf("b2b_busy k=%0d", k), 32'(busy_w[0]), 32'(k <= 120));
      chk($sformatf("b2b_rinc k=%0d", k), 32'(rinc_w[0]), 32'(k == 40 || k == 80));
      if (rinc_w[0] === 1'b1) pops++;
    end
    chk("b2b_pop_count", 32'(pops), 32'd3);
    chk("b2b_fifo_drained", 32'(fhead[0]), 32'(ftail[0]));

    // en dropped mid-frame, re-raised, then reset during DATA bit 3
    @(negedge clk);
    push_word(0, 8'h5A); exp_q.push_back(8'h5A);
    push_word(0, 8'h81); exp_q.push_back(8'h81);
    push_word(0, 8'hC3); exp_q.push_back(8'hC3);
    #1;
    chk("endrop_first_pop", 32'(rinc_w[0]), 32'd1);
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 10) en_w[0] = 1'b0;
      #1;
      chk($sformatf("endrop_rinc k=%0d", k), 32'(rinc_w[0]), 32'd0);
      if (k == 40) chk("endrop_busy_last_stop", 32'(busy_w[0]), 32'd1);
      if (k >= 41) begin
        chk($sformatf("endrop_idle_busy k=%0d", k), 32'(busy_w[0]), 32'd0);
        chk($sformatf("endrop_idle_tx k=%0d", k), 32'(tx_w[0]), 32'd1);
      end
    end
    @(negedge clk);
    en_w[0] = 1'b1;
    #1;
    chk("en_reraise_pop", 32'(rinc_w[0]), 32'd1);
    for (int k = 46; k <= 62; k++) begin
      @(negedge clk); #1;
      if (k == 46) begin
        chk("reraise_start_tx", 32'(tx_w[0]), 32'd0);
        chk("reraise_start_busy", 32'(busy_w[0]), 32'd1);
      end
    end
    @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    chk("rst_assert_rinc", 32'(rinc_w[0]), 32'd0);
    for (int k = 64; k <= 65; k++) begin
      @(negedge clk); #1;
      chk($sformatf("rst_tx k=%0d", k), 32'(tx_w[0]), 32'd1);
      chk($sformatf("rst_busy k=%0d", k), 32'(busy_w[0]), 32'd0);
      chk($sformatf("rst_rinc k=%0d", k), 32'(rinc_w[0]), 32'd0);
      chk($sformatf("rst_state k=%0d", k), 32'(state_w[0]), 32'd0);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    #1;
    chk("post_rst_pop", 32'(rinc_w[0]), 32'd1);
    @(negedge clk); #1;
    chk("post_rst_start_tx", 32'(tx_w[0]), 32'd0);
    chk("post_rst_start_busy", 32'(busy_w[0]), 32'd1);
    void'(exp_q.pop_front());  // 0x5A: checked by the timing loop above
    void'(exp_q.pop_front());  // 0x81: discarded by the reset
    uart_rx(0, 4, 0, 1, 20, w, ok);
    chk("post_rst_frame_ok", 32'(ok), 32'd1);
    chk("post_rst_word", 32'(w), 32'(exp_q.pop_front()));
    chk("post_rst_no_repop", 32'(fhead[0]), 32'(ftail[0]));

    // parity frames on 0xA5: even (bit 0, F=44), odd + 2 stops (bit 1, F=48)
    for (int pi = 0; pi < 2; pi++) begin
      int g;
      g  = pi + 1;
      fl = (pi == 0) ? 44 : 48;
      @(negedge clk);
      en_w[g] = 1'b1;
      push_word(g, 8'hA5);
      #1;
      chk($sformatf("par%0d_pop", pi + 1), 32'(rinc_w[g]), 32'd1);
      for (int k = 1; k <= fl + 1; k++) begin
        @(negedge clk); #1;
        chk($sformatf("par%0d_busy k=%0d", pi + 1, k), 32'(busy_w[g]), 32'(k <= fl));
        if (k == 38) chk($sformatf("par%0d_bit", pi + 1), 32'(tx_w[g]), 32'(pi));
        if (k >= 41) chk($sformatf("par%0d_stop_tx k=%0d", pi + 1, k), 32'(tx_w[g]), 32'd1);
      end
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        w = 8'($urandom_range(0, 255));
        push_word(g, w);
        exp_q.push_back(w);
      end
      #1;
      for (int i = 0; i < 6; i++) begin
        uart_rx(g, 4, pi + 1, pi + 1, 30, w, ok);
        chk($sformatf("par%0d_rx_ok i=%0d", pi + 1, i), 32'(ok), 32'd1);
        chk($sformatf("par%0d_rx_word i=%0d", pi + 1, i), 32'(w), 32'(exp_q.pop_front()));
      end
    end

    // minimum divisor, 256 random words, receiver model
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom_range(0, 255));
      push_word(3, w);
      exp_q.push_back(w);
    end
    en_w[3] = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) begin
      uart_rx(3, 2, 0, 1, 40, w, ok);
      chk($sformatf("div2_rx_ok i=%0d", i), 32'(ok), 32'd1);
      chk($sformatf("div2_rx_word i=%0d", i), 32'(w), 32'(exp_q.size() > 0 ? exp_q.pop_front() : 8'h00));
    end
    repeat (4) @(negedge clk);
    #1;
    chk("div2_pop_count", 32'(fhead[3]), 32'd256);
    chk("div2_idle_tx", 32'(tx_w[3]), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("rinc_protocol_violations", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
